// File: rtl/timer_simple.sv
// Purpose: single-shot, retriggerable timeout counter (watchdog / settle delay).
// Latency: timer_timeout rises TIMEOUT edges after the last arm edge; it drops on the arm edge itself.
// Backpressure: none; reset/start are level inputs that are sampled on every edge, and the output is a sticky level.
//
// Ports:
//   clk           - rising-edge clock
//   reset         - synchronous, active-high; clears and arms the timer
//   start         - level-sensitive re-arm; every edge sampled high restarts the count
//   timer_timeout - registered flag, high once TIMEOUT edges have passed since the last arm
//
// Parameters:
//   TIMEOUT - arm-to-timeout distance in cycles, 1 .. 2**CNT_W-1
//   CNT_W   - counter width, must hold TIMEOUT

module timer_simple #(
   parameter int unsigned TIMEOUT = 1000,
   parameter int unsigned CNT_W   = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic timer_timeout
);

   // Terminal count at counter width, so every comparison is width-matched.
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   // The timer phase is a pure decode of the counter: the counter parks at
   // TIMEOUT_C once expired, so no separate phase register is needed.
   typedef enum logic {
      RUNNING = 1'b0,
      EXPIRED = 1'b1
   } tmr_state_e;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             timeout_q;
   logic             timeout_d;
   logic             arm;
   tmr_state_e       state;

   assign arm   = reset | start;
   assign state = (cnt_q == TIMEOUT_C) ? EXPIRED : RUNNING;

   // Cannot overflow: it is only used while cnt_q < TIMEOUT_C <= 2**CNT_W-1.
   assign cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

   always_comb begin
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      if (arm) begin
         // Reset and start are equivalent arm events; holding either pins the count at 0.
         cnt_d     = '0;
         timeout_d = 1'b0;
      end else begin
         case (state)
            RUNNING: begin
               cnt_d     = cnt_inc;
               timeout_d = (cnt_inc == TIMEOUT_C);
            end
            EXPIRED: begin
               // Saturate rather than wrap so the flag stays sticky indefinitely.
               cnt_d     = cnt_q;
               timeout_d = 1'b1;
            end
            default: begin
               cnt_d     = '0;
               timeout_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Output comes straight from a flop: glitch-free, no input-to-output path.
   assign timer_timeout = timeout_q;

endmodule

// File: tb/tb_timer_simple.sv
// Purpose: self-checking bench for timer_simple at TIMEOUT=1000, a narrow saturating instance and TIMEOUT=1.
// Latency: every edge is compared against a model of "edges since the last arm".
// Backpressure: not applicable; inputs are driven each cycle from one directed/random sequence.

module tb_timer_simple;

   localparam int TA = 1000;  // main instance, 16-bit counter
   localparam int TB = 7;     // TIMEOUT equals the counter maximum (3 bits) -> wrap check
   localparam int TC = 1;     // minimum timeout

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic to_a;
   logic to_b;
   logic to_c;

   int vectors = 0;
   int miscompares = 0;
   int since_a = 0;
   int since_b = 0;
   int since_c = 0;
   string phase = "init";

   always #5 clk = ~clk;

   timer_simple #(.TIMEOUT(TA), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .start(start), .timer_timeout(to_a)
   );
   timer_simple #(.TIMEOUT(TB), .CNT_W(3)) dut_b (
      .clk(clk), .reset(reset), .start(start), .timer_timeout(to_b)
   );
   timer_simple #(.TIMEOUT(TC), .CNT_W(4)) dut_c (
      .clk(clk), .reset(reset), .start(start), .timer_timeout(to_c)
   );

   function automatic int exp_cnt(input int since, input int t);
      return (since >= t) ? t : since;
   endfunction

   function automatic int exp_to(input int since, input int t);
      return (since >= t) ? 1 : 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv)
      else begin
         miscompares++;
         $error("FAIL %s/%s: observed %0d expected %0d (t=%0t)", phase, tag, obs, expv, $time);
      end
   endtask

   // Apply one cycle of inputs, advance the model by one edge, check all outputs.
   task automatic step(input logic r, input logic s);
      reset = r;
      start = s;
      @(posedge clk);
      if (r || s) begin
         since_a = 0;
         since_b = 0;
         since_c = 0;
      end else begin
         since_a++;
         since_b++;
         since_c++;
      end
      #1;
      check("a_timeout", 32'(to_a), 32'(exp_to(since_a, TA)));
      check("a_cnt", 32'(dut_a.cnt_q), 32'(exp_cnt(since_a, TA)));
      check("b_timeout", 32'(to_b), 32'(exp_to(since_b, TB)));
      check("b_cnt", 32'(dut_b.cnt_q), 32'(exp_cnt(since_b, TB)));
      check("c_timeout", 32'(to_c), 32'(exp_to(since_c, TC)));
      check("c_cnt", 32'(dut_c.cnt_q), 32'(exp_cnt(since_c, TC)));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   initial begin
      phase = "reset";
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);

      // Rise on edge 1000 after release, then stay high for 5000 more cycles.
      phase = "release";
      idle(TA + 5000);

      phase = "retrigger";
      step(1'b0, 1'b1);
      idle(6);
      step(1'b0, 1'b1);
      idle(TA + 100);

      phase = "long_start";
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
      idle(TA + 100);

      // Timer is expired here; a one-cycle start drops the output on that edge.
      phase = "rearm_expired";
      step(1'b0, 1'b1);
      idle(TA + 100);

      phase = "reset_mid";
      idle(500);
      step(1'b1, 1'b0);
      idle(TA + 100);

      phase = "reset_and_start";
      idle(300);
      step(1'b1, 1'b1);
      idle(TA + 100);

      phase = "random";
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 999) == 0), ($urandom_range(0, 149) == 0));
      end

      phase = "saturate";
      idle(3000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
